// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Write-side controller for the async FIFO storage array. Two requesters
//   share the single memory write port under round-robin arbitration. The
//   block owns the binary and Gray write pointers and produces a registered
//   full flag against the read pointer already synchronized into wclk.
//   Optional almost-full output is enabled by defining WARB_AFULL_EN.
//
// Handshake: reqN acts as a valid and stays high, with dataN stable, until
//   the cycle in which gntN is high. gntN is a combinational accept. A write
//   takes place on every wclk edge where gntN=1, so a request is accepted
//   with zero-cycle latency and is never dropped once granted.
module fifo_write_arbiter #(
  parameter int WIDTH           = 8,
  parameter int no_of_addresses = 16,
  parameter int address_bits    = $clog2(no_of_addresses),
  parameter int AFULL_THRESH    = 12
) (
  input  logic                    wclk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic [WIDTH-1:0]        data0,
  input  logic                    req1,
  input  logic [WIDTH-1:0]        data1,
  output logic                    gnt0,
  output logic                    gnt1,
  input  logic [address_bits:0]   wq2_rptr,
  output logic                    wclken,
  output logic [address_bits-1:0] waddr,
  output logic [WIDTH-1:0]        wdata,
  output logic [address_bits:0]   wptr,
  output logic                    wfull
`ifdef WARB_AFULL_EN
  ,
  output logic                    wafull
`endif
);

  localparam int AW = address_bits;

  // Registered state
  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wptr_q, wptr_d;
  logic        wfull_q, wfull_d;
  logic        last_q, last_d;

  // Read pointer with its two MSBs inverted: equal to the write Gray
  // pointer exactly when the write side is one full lap ahead.
  logic [AW:0] rptr_full_cmp;

  // Round-robin grant; a full FIFO or an active reset blocks every grant.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !wfull_q) begin
      if (req0 && req1) begin
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign wclken = gnt0 | gnt1;
  assign wdata  = gnt1 ? data1 : data0;
  assign waddr  = wbin_q[AW-1:0];
  assign wptr   = wptr_q;
  assign wfull  = wfull_q;

  assign rptr_full_cmp = {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]};

  // Next-state pointers, full flag and round-robin history.
  always_comb begin
    wbin_d  = wbin_q;
    last_d  = last_q;
    if (wclken) begin
      wbin_d = wbin_q + 1'b1;
      last_d = gnt1;
    end
    wptr_d  = wbin_d ^ (wbin_d >> 1);
    wfull_d = (wptr_d == rptr_full_cmp);
  end

  // Pointer, full flag and arbitration state registers.
  always_ff @(posedge wclk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wptr_d;
      wfull_q <= wfull_d;
      last_q  <= last_d;
    end
  end

`ifdef WARB_AFULL_EN
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

  logic [AW:0] rbin;
  logic [AW:0] fill_d;
  logic        wafull_q, wafull_d;

  // Convert the synchronized Gray read pointer back to binary.
  always_comb begin
    rbin[AW] = wq2_rptr[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
    end
  end

  // Occupancy after this edge's write, compared against the threshold.
  always_comb begin
    fill_d   = wbin_d - rbin;
    wafull_d = (fill_d >= AFULL_LVL);
  end

  // Almost-full register, refreshed on every edge.
  always_ff @(posedge wclk) begin
    if (rst) wafull_q <= 1'b0;
    else     wafull_q <= wafull_d;
  end

  assign wafull = wafull_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
//   Directed bench for fifo_write_arbiter: single writes, round-robin
//   alternation, fill to full, release by a read, address wrap, reset during
//   a grant, and (with WARB_AFULL_EN) the almost-full threshold.
module tb_fifo_write_arbiter;

  localparam int WIDTH = 8;
  localparam int AW    = 4;

  // Clock / reset
  logic             wclk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1;
  logic [AW:0]      wq2_rptr;
  logic             wclken;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW:0]      wptr;
  logic             wfull;
`ifdef WARB_AFULL_EN
  logic             wafull;
`endif

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(
    .WIDTH(WIDTH),
    .no_of_addresses(16),
    .address_bits(AW),
    .AFULL_THRESH(12)
  ) dut (
    .wclk(wclk),
    .rst(rst),
    .req0(req0),
    .data0(data0),
    .req1(req1),
    .data1(data1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .wq2_rptr(wq2_rptr),
    .wclken(wclken),
    .waddr(waddr),
    .wdata(wdata),
    .wptr(wptr),
    .wfull(wfull)
`ifdef WARB_AFULL_EN
    ,
    .wafull(wafull)
`endif
  );

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    rst  = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    data0    = '0;
    data1    = '0;
    wq2_rptr = '0;
    step();
    step();

    // Reset state, and grants forced off while rst is high
    check("reset_wptr", 32'(wptr), 32'h0);
    check("reset_wfull", 32'(wfull), 32'h0);
    check("reset_waddr", 32'(waddr), 32'h0);
    req0 = 1'b1;
    settle();
    check("rst_gnt0", 32'(gnt0), 32'h0);
    check("rst_wclken", 32'(wclken), 32'h0);
`ifdef WARB_AFULL_EN
    check("reset_wafull", 32'(wafull), 32'h0);
`endif
    step();

    // Single write from requester 0
    rst   = 1'b0;
    req0  = 1'b1;
    data0 = 8'hA5;
    settle();
    check("single_gnt0", 32'(gnt0), 32'h1);
    check("single_gnt1", 32'(gnt1), 32'h0);
    check("single_wclken", 32'(wclken), 32'h1);
    check("single_waddr", 32'(waddr), 32'h0);
    check("single_wdata", 32'(wdata), 32'hA5);
    step();
    req0 = 1'b0;
    settle();
    check("single_wptr", 32'(wptr), 32'h01);
    check("single_waddr_next", 32'(waddr), 32'h1);
    check("idle_wclken", 32'(wclken), 32'h0);

    // Both requesting: grants alternate 0,1,0,1 starting after reset
    do_reset();
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h10;
    data1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_gnt1", 32'(gnt1), (i % 2 == 1) ? 32'h1 : 32'h0);
      check("rr_waddr", 32'(waddr), 32'(i));
      check("rr_wdata", 32'(wdata), (i % 2 == 0) ? 32'h10 : 32'h20);
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Fill 16 entries with no reads
    do_reset();
    wq2_rptr = '0;
    req0     = 1'b1;
    data0    = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("fill_gnt0", 32'(gnt0), 32'h1);
      check("fill_waddr", 32'(waddr), 32'(i));
      check("fill_wfull_before", 32'(wfull), 32'h0);
      step();
    end
    check("full_wfull", 32'(wfull), 32'h1);
    check("full_wptr", 32'(wptr), 32'h18);
    settle();
    check("full_gnt0", 32'(gnt0), 32'h0);
    check("full_wclken", 32'(wclken), 32'h0);
    check("full_waddr", 32'(waddr), 32'h0);
    step();
    check("full_hold", 32'(wfull), 32'h1);

    // One read becomes visible: full drops, one more write refills
    wq2_rptr = 5'b00001;
    step();
    check("release_wfull", 32'(wfull), 32'h0);
    settle();
    check("release_gnt0", 32'(gnt0), 32'h1);
    check("release_waddr", 32'(waddr), 32'h0);
    step();
    req0 = 1'b0;
    check("refill_wfull", 32'(wfull), 32'h1);
    check("refill_waddr", 32'(waddr), 32'h1);

    // 20 writes with the read pointer tracking: address wrap
    do_reset();
    req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wq2_rptr = gray(5'(i));
      data0    = 8'(i + 1);
      settle();
      check("wrap_gnt0", 32'(gnt0), 32'h1);
      if (i == 15 || i == 16 || i == 19) begin
        check("wrap_waddr", 32'(waddr), 32'(i % 16));
        check("wrap_wdata", 32'(wdata), 32'(i + 1));
      end
      step();
    end
    check("wrap_wptr", 32'(wptr), 32'h1E);
    check("wrap_wfull", 32'(wfull), 32'h0);

    // Reset asserted during a granting cycle
    settle();
    check("pre_rst_gnt0", 32'(gnt0), 32'h1);
    rst = 1'b1;
    settle();
    check("midrst_gnt0", 32'(gnt0), 32'h0);
    check("midrst_wclken", 32'(wclken), 32'h0);
    step();
    check("midrst_wptr", 32'(wptr), 32'h0);
    check("midrst_wfull", 32'(wfull), 32'h0);
    rst  = 1'b0;
    req0 = 1'b0;

`ifdef WARB_AFULL_EN
    // Almost-full threshold at 12 unread entries
    do_reset();
    wq2_rptr = '0;
    req0     = 1'b1;
    for (int i = 0; i < 11; i++) step();
    check("afull_11", 32'(wafull), 32'h0);
    step();
    check("afull_12", 32'(wafull), 32'h1);
    req0 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
